// File: rtl/decoder_scan_seq.sv
// Scan address generator driving the select and enable of a 4-to-16 decoder.
// Optional build macro SCAN_SKIP_MASK_EN adds a skip_mask input that removes addresses from the scan.
module decoder_scan_seq #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        oneshot,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [15:0] skip_mask,
`endif
    output logic [3:0]  w,
    output logic        en,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

    localparam logic [7:0] DwellLast = 8'(DWELL - 1);
    localparam logic [7:0] BlankLast = 8'(BLANK - 1);
    localparam bit         HasBlank  = (BLANK != 0);

    state_e     state_q, state_d;
    logic [3:0] w_q, w_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] frame_q, frame_d;
    logic       stop_q, stop_d;
    logic       os_q, os_d;
    logic       en_q, en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [15:0] mask;
`ifdef SCAN_SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask = 16'h0000;
`endif

    // Next unmasked address after w_q; adv_wrap marks that the step crosses past address 15.
    logic [3:0] adv_addr;
    logic       adv_wrap;
    logic       adv_none;
    logic [4:0] sum;
    always_comb begin
        adv_addr = w_q;
        adv_wrap = 1'b0;
        adv_none = 1'b1;
        sum      = 5'd0;
        for (int i = 1; i <= 16; i++) begin
            sum = {1'b0, w_q} + 5'(i);
            if (adv_none && !mask[sum[3:0]]) begin
                adv_addr = sum[3:0];
                adv_wrap = sum[4];
                adv_none = 1'b0;
            end
        end
    end

    logic [3:0] first_addr;
    logic       first_none;
    always_comb begin
        first_addr = 4'd0;
        first_none = &mask;
        for (int i = 15; i >= 0; i--) begin
            if (!mask[i]) first_addr = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        stop_d  = stop_q;
        os_d    = os_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (start && !first_none) begin
                    state_d = StActive;
                    w_d     = first_addr;
                    cnt_d   = 8'd0;
                    os_d    = oneshot;
                end
            end
            StActive: begin
                if (stop) stop_d = 1'b1;
                if (cnt_q == DwellLast) begin
                    cnt_d = 8'd0;
                    if (adv_wrap) begin
                        frame_d = frame_q + 8'd1;
                        done_d  = 1'b1;
                    end
                    // A stop arriving on this very edge still counts.
                    if (stop_q || stop || adv_none || (os_q && adv_wrap)) begin
                        state_d = StIdle;
                        w_d     = 4'd0;
                        stop_d  = 1'b0;
                    end else if (HasBlank) begin
                        state_d = StBlank;
                    end else begin
                        w_d = adv_addr;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StBlank: begin
                if (stop) stop_d = 1'b1;
                if (cnt_q == BlankLast) begin
                    cnt_d = 8'd0;
                    if (stop_q || stop || adv_none) begin
                        state_d = StIdle;
                        w_d     = 4'd0;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = StActive;
                        w_d     = adv_addr;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                w_d     = 4'd0;
            end
        endcase
        en_d   = (state_d == StActive);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            w_q     <= 4'd0;
            cnt_q   <= 8'd0;
            frame_q <= 8'd0;
            stop_q  <= 1'b0;
            os_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            stop_q  <= stop_d;
            os_q    <= os_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign w         = w_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: instance a uses DWELL=4/BLANK=1, instance b DWELL=2/BLANK=0.
module tb_decoder_scan_seq;

    logic clk = 1'b0;
    logic rst;
    logic start_a, stop_a, oneshot_a;
    logic start_b, stop_b, oneshot_b;
    logic [3:0] w_a, w_b;
    logic en_a, en_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] frame_cnt_a, frame_cnt_b;
`ifdef SCAN_SKIP_MASK_EN
    logic [15:0] skip_mask;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    decoder_scan_seq #(.DWELL(4), .BLANK(1)) u_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .stop      (stop_a),
        .oneshot   (oneshot_a),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask (skip_mask),
`endif
        .w         (w_a),
        .en        (en_a),
        .busy      (busy_a),
        .done      (done_a),
        .frame_cnt (frame_cnt_a)
    );

    decoder_scan_seq #(.DWELL(2), .BLANK(0)) u_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .stop      (stop_b),
        .oneshot   (oneshot_b),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask (skip_mask),
`endif
        .w         (w_b),
        .en        (en_b),
        .busy      (busy_b),
        .done      (done_b),
        .frame_cnt (frame_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dn;
        rst = 1'b1;
        start_a = 1'b0; stop_a = 1'b0; oneshot_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; oneshot_b = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
        skip_mask = 16'h0000;
`endif
        repeat (2) tick();
        check("rst_w", 32'(w_a), 0);
        check("rst_en", 32'(en_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_frame", 32'(frame_cnt_a), 0);
        rst = 1'b0;
        tick();

        // One-shot frame on a: 15 addresses of 4+1 cycles, then 4 cycles at 15.
        oneshot_a = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        dn = 0;
        for (int c = 0; c < 79; c++) begin
            check("a_w", 32'(w_a), 32'(c / 5));
            check("a_en", 32'(en_a), 32'((c % 5) < 4));
            check("a_busy", 32'(busy_a), 1);
            dn += int'(done_a);
            tick();
        end
        check("a_done_early", 32'(dn), 0);
        check("a_idle_busy", 32'(busy_a), 0);
        check("a_idle_en", 32'(en_a), 0);
        check("a_idle_w", 32'(w_a), 0);
        check("a_done", 32'(done_a), 1);
        check("a_frame", 32'(frame_cnt_a), 1);
        tick();
        check("a_done_once", 32'(done_a), 0);

        // Continuous on b for 3 frames, no gaps, wrap 15->0.
        oneshot_b = 1'b0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 0; c < 96; c++) begin
            check("b_w", 32'(w_b), 32'((c / 2) % 16));
            check("b_en", 32'(en_b), 1);
            check("b_done", 32'(done_b), 32'(c == 32 || c == 64));
            tick();
        end
        check("b_done3", 32'(done_b), 1);
        check("b_frame3", 32'(frame_cnt_b), 3);
        check("b_wrap_w", 32'(w_b), 0);

        // Stop mid-dwell at address 5.
        repeat (10) tick();
        check("b_w5", 32'(w_b), 5);
        stop_b = 1'b1;
        tick();
        stop_b = 1'b0;
        check("b_stop_dwell_w", 32'(w_b), 5);
        check("b_stop_dwell_en", 32'(en_b), 1);
        tick();
        check("b_stop_busy", 32'(busy_b), 0);
        check("b_stop_en", 32'(en_b), 0);
        check("b_stop_w", 32'(w_b), 0);
        check("b_stop_done", 32'(done_b), 0);
        check("b_stop_frame", 32'(frame_cnt_b), 3);

        // start held through a one-shot frame, including the IDLE return edge.
        oneshot_b = 1'b1; start_b = 1'b1;
        tick();
        for (int c = 0; c < 31; c++) begin
            check("b_hold_w", 32'(w_b), 32'(c / 2));
            tick();
        end
        check("b_hold_busy", 32'(busy_b), 1);
        check("b_hold_w15", 32'(w_b), 15);
        tick();
        check("b_hold_idle", 32'(busy_b), 0);
        check("b_hold_done", 32'(done_b), 1);
        check("b_hold_frame", 32'(frame_cnt_b), 4);
        start_b = 1'b0;
        tick();
        check("b_no_restart", 32'(busy_b), 0);

        // start and stop together in IDLE: start wins, stop not latched.
        start_b = 1'b1; stop_b = 1'b1;
        tick();
        start_b = 1'b0; stop_b = 1'b0;
        check("b_ss_busy", 32'(busy_b), 1);
        check("b_ss_w", 32'(w_b), 0);
        check("b_ss_en", 32'(en_b), 1);
        repeat (2) tick();
        check("b_ss_w1", 32'(w_b), 1);
        check("b_ss_busy1", 32'(busy_b), 1);

        // Async reset mid-dwell at address 9 on a (continuous).
        oneshot_a = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (46) tick();
        check("a_w9", 32'(w_a), 9);
        check("a_w9_en", 32'(en_a), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_w", 32'(w_a), 0);
        check("arst_en", 32'(en_a), 0);
        check("arst_busy", 32'(busy_a), 0);
        check("arst_frame", 32'(frame_cnt_a), 0);
        check("arst_b_busy", 32'(busy_b), 0);
        check("arst_b_frame", 32'(frame_cnt_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_restart_w", 32'(w_a), 0);
        check("a_restart_en", 32'(en_a), 1);
        check("a_restart_busy", 32'(busy_a), 1);

`ifdef SCAN_SKIP_MASK_EN
        // Only addresses 0..3 unmasked.
        skip_mask = 16'hFFF0;
        oneshot_b = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("skip_w", 32'(w_b), 32'(c / 2));
            check("skip_busy", 32'(busy_b), 1);
            tick();
        end
        check("skip_idle", 32'(busy_b), 0);
        check("skip_done", 32'(done_b), 1);
        check("skip_frame", 32'(frame_cnt_b), 1);
        skip_mask = 16'hFFFF;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("skip_all_start", 32'(busy_b), 0);
        repeat (6) tick();
        check("skip_all_abort", 32'(busy_a), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
